uart_rx_drain_ctrl: RTL and testbench

- Controller that sequences the UART receiver's single holding register and drains it into a local FIFO.
- Watches the receiver's data_ready flag, captures the byte and its status, and returns a one-cycle data_readed acknowledge.
- Presents received bytes to the downstream consumer as a valid/ready stream.
- Keeps saturating error statistics (parity, overrun, FIFO drop) for the host register block.

---
 rtl/uart_rx_drain_ctrl_if.sv | 21 ++
 rtl/uart_rx_drain_ctrl.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_drain_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_drain_ctrl_if.sv
// rtl/uart_rx_drain_ctrl_if.sv - received-byte stream from the drain FIFO head to the consumer
//
// Signals:
//   m_valid  FIFO head holds a byte
//   m_data   FIFO head byte
//   m_perr   parity flag stored with the head byte
//   m_ready  consumer takes the head when m_valid && m_ready
// Modports:
//   master   producer side (the drain controller)
//   slave    consumer side
interface uart_rx_drain_ctrl_if #(
  parameter int DATA_LEN = 8
);
  logic                m_valid;
  logic [DATA_LEN-1:0] m_data;
  logic                m_perr;
  logic                m_ready;

  modport master (output m_valid, output m_data, output m_perr, input m_ready);
  modport slave  (input m_valid, input m_data, input m_perr, output m_ready);
endinterface

// File: rtl/uart_rx_drain_ctrl.sv
// rtl/uart_rx_drain_ctrl.sv - drains the UART receiver holding register into a local FIFO
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   en                drain enable; no new capture starts while low
//   rx_data_ready     receiver holding register full
//   rx_data           receiver byte
//   rx_parity_error   parity flag of the held byte
//   rx_overwritten    overwrite flag of the held byte
//   rx_data_readed    one-cycle acknowledge back to the receiver
//   m_if              byte stream to the consumer (master side)
//   fifo_level        FIFO occupancy, 0..FIFO_DEPTH
//   perr_cnt          saturating count of parity-errored bytes captured
//   ovr_cnt           saturating count of bytes captured with rx_overwritten
//   drop_cnt          saturating count of bytes discarded on a full FIFO
//   clr_stats         synchronous clear of the three counters
module uart_rx_drain_ctrl #(
  parameter int DATA_LEN   = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          rx_data_ready,
  input  logic [DATA_LEN-1:0]           rx_data,
  input  logic                          rx_parity_error,
  input  logic                          rx_overwritten,
  output logic                          rx_data_readed,
  uart_rx_drain_ctrl_if.master          m_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              perr_cnt,
  output logic [CNT_W-1:0]              ovr_cnt,
  output logic [CNT_W-1:0]              drop_cnt,
  input  logic                          clr_stats
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACK      = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Each entry is {parity_flag, byte}.
  logic [DATA_LEN:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  logic fifo_full;
  logic capture;
  logic pop;
  logic push;
  logic drop;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // en only gates the start of a transaction; once in CAPTURE the sequence
  // always runs to completion so the receiver is never left unacknowledged.
  // WAIT_CLR holds off until the receiver drops data_ready, otherwise the
  // same held byte would be captured a second time.
  always_comb begin
    state_next     = state;
    rx_data_readed = 1'b0;
    case (state)
      IDLE: begin
        if (en && rx_data_ready) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        state_next = ACK;
      end
      ACK: begin
        rx_data_readed = 1'b1;
        state_next     = WAIT_CLR;
      end
      WAIT_CLR: begin
        if (!rx_data_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign fifo_full = (fifo_level == LW'(FIFO_DEPTH));
  assign capture   = (state == CAPTURE);
  assign pop       = m_if.m_valid && m_if.m_ready;
  // A pop in the capture cycle frees the slot at the same edge, so a full
  // FIFO can still accept the byte.
  assign push      = capture && (!fifo_full || pop);
  assign drop      = capture && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {rx_parity_error, rx_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Head is read straight from the array so it always shows the entry at the
  // read pointer; entries are cleared on reset so the head reads zero then.
  assign m_if.m_valid = (fifo_level != '0);
  assign m_if.m_data  = mem[rd_ptr][DATA_LEN-1:0];
  assign m_if.m_perr  = mem[rd_ptr][DATA_LEN];

  // ---------------------------------------------------------------------------
  // Statistics: saturate at all-ones, clear wins over a same-cycle increment
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perr_cnt <= '0;
    end else if (clr_stats) begin
      perr_cnt <= '0;
    end else if (capture && rx_parity_error && !(&perr_cnt)) begin
      perr_cnt <= perr_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_cnt <= '0;
    end else if (clr_stats) begin
      ovr_cnt <= '0;
    end else if (capture && rx_overwritten && !(&ovr_cnt)) begin
      ovr_cnt <= ovr_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (clr_stats) begin
      drop_cnt <= '0;
    end else if (drop && !(&drop_cnt)) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_rx_drain_ctrl.sv
// tb/tb_uart_rx_drain_ctrl.sv - scoreboard bench for uart_rx_drain_ctrl
module tb_uart_rx_drain_ctrl;

  localparam int DL    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = 8;
  localparam int CW2   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          rx_data_ready = 1'b0;
  logic [DL-1:0] rx_data = '0;
  logic          rx_parity_error = 1'b0;
  logic          rx_overwritten = 1'b0;
  logic          clr_stats = 1'b0;

  logic           readed, readed2;
  logic [3:0]     level, level2;
  logic [CW-1:0]  perr, ovr, drop;
  logic [CW2-1:0] perr2, ovr2, drop2;

  uart_rx_drain_ctrl_if #(.DATA_LEN(DL)) m_if ();
  uart_rx_drain_ctrl_if #(.DATA_LEN(DL)) m_if2 ();

  always #5 clk = ~clk;

  uart_rx_drain_ctrl #(.DATA_LEN(DL), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_parity_error(rx_parity_error), .rx_overwritten(rx_overwritten),
    .rx_data_readed(readed), .m_if(m_if), .fifo_level(level),
    .perr_cnt(perr), .ovr_cnt(ovr), .drop_cnt(drop), .clr_stats(clr_stats)
  );

  // Narrow-counter copy on the same stimulus, for saturation.
  uart_rx_drain_ctrl #(.DATA_LEN(DL), .FIFO_DEPTH(DEPTH), .CNT_W(CW2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .rx_data_ready(rx_data_ready), .rx_data(rx_data),
    .rx_parity_error(rx_parity_error), .rx_overwritten(rx_overwritten),
    .rx_data_readed(readed2), .m_if(m_if2), .fifo_level(level2),
    .perr_cnt(perr2), .ovr_cnt(ovr2), .drop_cnt(drop2), .clr_stats(clr_stats)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;

  // Reference model state
  bit            pend = 1'b0;
  int            pend_edge = -1;
  logic [DL-1:0] pend_data;
  logic          pend_pe, pend_ov;
  int            ack_edge = -1;
  int            mdl_level = 0;
  int            mp = 0, mo = 0, md = 0;
  logic [DL:0]   sb_q[$];
  bit            m_pop, m_push, m_cap;
  int            rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: a bounded queue. A byte whose ready was sampled at edge E is
  // offered at edge E+1; it is kept if there is room or the head leaves then.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_pop  = (mdl_level > 0) && m_if.m_ready;
      m_cap  = pend && (cyc == pend_edge);
      m_push = m_cap && ((mdl_level < DEPTH) || m_pop);
      if (m_push) sb_q.push_back({pend_pe, pend_data});
      mdl_level = mdl_level + int'(m_push) - int'(m_pop);
      if (m_cap) begin
        pend     = 1'b0;
        ack_edge = cyc;
      end
      if (clr_stats) begin
        mp = 0; mo = 0; md = 0;
      end else if (m_cap) begin
        if (pend_pe) mp = sat(mp + 1, 255);
        if (pend_ov) mo = sat(mo + 1, 255);
        if (!m_push) md = sat(md + 1, 255);
      end
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst && mon_on) begin
      chk("rx_data_readed", readed, 32'(ack_edge == cyc));
      chk("rx_data_readed2", readed2, 32'(ack_edge == cyc));
      chk("fifo_level", level, mdl_level);
      chk("fifo_level2", level2, mdl_level);
      chk("m_valid", m_if.m_valid, 32'(mdl_level != 0));
      chk("perr_cnt", perr, mp);
      chk("ovr_cnt", ovr, mo);
      chk("drop_cnt", drop, md);
      chk("perr_cnt_w2", perr2, sat(mp, 3));
      chk("ovr_cnt_w2", ovr2, sat(mo, 3));
      chk("drop_cnt_w2", drop2, sat(md, 3));
      if (m_if.m_valid && m_if.m_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_output", m_if.m_valid, 0);
        end else begin
          logic [DL:0] e;
          e = sb_q.pop_front();
          chk("m_data", m_if.m_data, e[DL-1:0]);
          chk("m_perr", m_if.m_perr, e[DL]);
          chk("m_data2", m_if2.m_data, e[DL-1:0]);
        end
      end
    end
  end

  // Consumer: 0 hold low, 1 hold high, 2 random, 3 high only in the capture cycle
  initial begin
    logic r;
    m_if.m_ready  = 1'b0;
    m_if2.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       r = 1'b0;
        1:       r = 1'b1;
        2:       r = 1'($urandom_range(0, 1));
        default: r = pend && (cyc + 1 == pend_edge);
      endcase
      m_if.m_ready  = r;
      m_if2.m_ready = r;
    end
  end

  // Receiver model: present one byte, optionally with en held low first,
  // keep data_ready high `hold` cycles past the acknowledge.
  task automatic send(input logic [DL-1:0] d, input logic pe, input logic ov, input int hold,
                      input int en_dly, input bit clr_cap, input bit en_drop);
    rx_data = d; rx_parity_error = pe; rx_overwritten = ov;
    rx_data_ready = 1'b1;
    en = 1'b0;
    repeat (en_dly) step();
    en = 1'b1;
    pend_data = d; pend_pe = pe; pend_ov = ov;
    pend_edge = cyc + 2;
    pend = 1'b1;
    step();
    if (clr_cap) clr_stats = 1'b1;
    if (en_drop) en = 1'b0;
    step();
    clr_stats = 1'b0;
    step();
    repeat (hold) step();
    rx_data_ready = 1'b0;
    rx_data = DL'($urandom);
    rx_parity_error = 1'($urandom);
    rx_overwritten = 1'($urandom);
    step();
  endtask

  task automatic clr_pulse();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
  endtask

  task automatic drain();
    rdy_mode = 1;
    for (int i = 0; i < 3 * DEPTH && mdl_level != 0; i++) step();
    step();
    rdy_mode = 0;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #1;
    chk("reset_readed", readed, 0);
    chk("reset_m_valid", m_if.m_valid, 0);
    chk("reset_m_data", m_if.m_data, 0);
    chk("reset_m_perr", m_if.m_perr, 0);
    chk("reset_level", level, 0);
    chk("reset_perr", perr, 0);
    chk("reset_ovr", ovr, 0);
    chk("reset_drop", drop, 0);
    step();
    step();
    rst = 1'b1;
    mon_on = 1'b1;
    step();

    // Single byte
    send(8'hA5, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("single_valid", m_if.m_valid, 1);
    chk("single_data", m_if.m_data, 8'hA5);
    chk("single_perr", m_if.m_perr, 0);
    chk("single_level", level, 1);
    drain();
    chk("single_level_after_pop", level, 0);

    // Fill plus overflow
    clr_pulse();
    for (int i = 0; i <= DEPTH; i++) send(DL'(i), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("ovf_level", level, DEPTH);
    chk("ovf_drop", drop, 1);
    drain();
    chk("ovf_level_drained", level, 0);

    // Full with a pop in the capture cycle
    clr_pulse();
    for (int i = 0; i < DEPTH; i++) send(DL'(8'h10 + i), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rdy_mode = 3;
    send(8'h18, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    rdy_mode = 0;
    step();
    chk("fullpop_level", level, DEPTH);
    chk("fullpop_drop", drop, 0);
    drain();

    // Error statistics and saturation of the narrow counters
    clr_pulse();
    rdy_mode = 1;
    send(8'h31, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    send(8'h32, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    send(8'h33, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    send(8'h34, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("stats_perr", perr, 3);
    chk("stats_ovr", ovr, 2);
    send(8'h35, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    send(8'h36, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("stats_perr5", perr, 5);
    chk("stats_perr_sat", perr2, 3);
    send(8'h37, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0);
    chk("clr_vs_inc_perr", perr, 0);
    chk("clr_vs_inc_ovr", ovr, 0);
    drain();

    // Enable held low, then sticky ready
    send(8'h5C, 1'b0, 1'b0, 4, 4, 1'b0, 1'b0);
    chk("sticky_level", level, 1);
    chk("sticky_data", m_if.m_data, 8'h5C);
    drain();

    // Reset during ACK with three bytes queued
    for (int i = 0; i < 3; i++) send(DL'(8'h60 + i), 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
    rx_data = 8'h63; rx_parity_error = 1'b0; rx_overwritten = 1'b0;
    rx_data_ready = 1'b1; en = 1'b1;
    pend_data = 8'h63; pend_pe = 1'b0; pend_ov = 1'b0;
    pend_edge = cyc + 2; pend = 1'b1;
    step();
    step();
    rst = 1'b0;
    pend = 1'b0; ack_edge = -1; mdl_level = 0; sb_q.delete();
    mp = 0; mo = 0; md = 0;
    rx_data_ready = 1'b0;
    #1;
    chk("midrst_readed", readed, 0);
    chk("midrst_valid", m_if.m_valid, 0);
    chk("midrst_level", level, 0);
    chk("midrst_perr", perr, 0);
    chk("midrst_ovr", ovr, 0);
    chk("midrst_m_data", m_if.m_data, 0);
    step();
    rst = 1'b1;
    step();
    send(8'h7E, 1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
    chk("postrst_level", level, 1);
    chk("postrst_data", m_if.m_data, 8'h7E);
    chk("postrst_perr", perr, 1);
    drain();

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      if (n % 16 == 0) rdy_mode = $urandom_range(0, 3);
      send(DL'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
           $urandom_range(0, 3), ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0,
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end

    drain();
    chk("final_scoreboard_empty", sb_q.size(), 0);
    chk("final_level", level, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
